// File: rtl/reservation_station_pkg.sv
// ============================================================================
// Module      : reservation_station_pkg
// Description : Shared opcodes, operand type and CDB resolve helper for the
//               integer/branch reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reservation_station_pkg;

  localparam int RS_SIZE_DEF   = 16;
  localparam int ROB_IDX_W_DEF = 4;
  localparam int OP_W_DEF      = 6;

  // Internal opcode encoding shared with the decoder and ALU
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_JALR = 6'd8;

  // One source operand: busy means still waiting on a ROB tag
  typedef struct packed {
    logic        busy;
    logic [31:0] val;
  } operand_t;

  // Resolve a possibly pending operand against the two CDBs; ALU wins a tie
  function automatic operand_t cdb_resolve(
    input logic        busy,
    input logic [31:0] val,
    input logic        alu_hit,
    input logic [31:0] alu_val,
    input logic        lsb_hit,
    input logic [31:0] lsb_val
  );
    operand_t res;
    res.busy = busy;
    res.val  = val;
    if (busy) begin
      if (alu_hit) begin
        res.busy = 1'b0;
        res.val  = alu_val;
      end else if (lsb_hit) begin
        res.busy = 1'b0;
        res.val  = lsb_val;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_priority_enc.sv
// ============================================================================
// Module      : rs_priority_enc
// Description : Request vector to valid flag plus lowest set index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_priority_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest requesting index is the last write
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reservation_station.sv
// ============================================================================
// Module      : reservation_station
// Description : Tomasulo reservation station feeding the combinational ALU.
//               Holds dispatched ops, snoops ALU/LSB CDBs, issues the lowest
//               ready entry each cycle through a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE   = RS_SIZE_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int OP_W      = OP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 ID_flag_in,
  input  logic [OP_W-1:0]      ID_op_in,
  input  logic                 ID_Q1_busy_in,
  input  logic [ROB_IDX_W-1:0] ID_Q1_in,
  input  logic [31:0]          ID_val1_in,
  input  logic                 ID_Q2_busy_in,
  input  logic [ROB_IDX_W-1:0] ID_Q2_in,
  input  logic [31:0]          ID_val2_in,
  input  logic [ROB_IDX_W-1:0] ID_idx_in_ROB_in,
  output logic                 RS_full_out,
  input  logic                 ALU_CDB_flag_in,
  input  logic [ROB_IDX_W-1:0] ALU_CDB_idx_in,
  input  logic [31:0]          ALU_CDB_val_in,
  input  logic                 LSB_CDB_flag_in,
  input  logic [ROB_IDX_W-1:0] LSB_CDB_idx_in,
  input  logic [31:0]          LSB_CDB_val_in,
  input  logic                 ROB_clear_in,
  output logic                 ALU_flag_out,
  output logic [OP_W-1:0]      ALU_op_out,
  output logic [31:0]          ALU_val1_out,
  output logic [31:0]          ALU_val2_out,
  output logic [ROB_IDX_W-1:0] ALU_idx_out
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry array
  logic [RS_SIZE-1:0]   busy_q, busy_d;
  logic [RS_SIZE-1:0]   qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0]   qk_busy_q, qk_busy_d;
  logic [OP_W-1:0]      op_q   [RS_SIZE];
  logic [OP_W-1:0]      op_d   [RS_SIZE];
  logic [ROB_IDX_W-1:0] qj_q   [RS_SIZE];
  logic [ROB_IDX_W-1:0] qj_d   [RS_SIZE];
  logic [ROB_IDX_W-1:0] qk_q   [RS_SIZE];
  logic [ROB_IDX_W-1:0] qk_d   [RS_SIZE];
  logic [31:0]          vj_q   [RS_SIZE];
  logic [31:0]          vj_d   [RS_SIZE];
  logic [31:0]          vk_q   [RS_SIZE];
  logic [31:0]          vk_d   [RS_SIZE];
  logic [ROB_IDX_W-1:0] dest_q [RS_SIZE];
  logic [ROB_IDX_W-1:0] dest_d [RS_SIZE];

  // Registered issue port
  logic                 alu_flag_q, alu_flag_d;
  logic [OP_W-1:0]      alu_op_q, alu_op_d;
  logic [31:0]          alu_val1_q, alu_val1_d;
  logic [31:0]          alu_val2_q, alu_val2_d;
  logic [ROB_IDX_W-1:0] alu_idx_q, alu_idx_d;

  logic [RS_SIZE-1:0]   ready;
  logic                 free_valid, issue_valid;
  logic [IDX_W-1:0]     free_idx, issue_idx;

  operand_t             snp_j [RS_SIZE];
  operand_t             snp_k [RS_SIZE];
  operand_t             disp_j, disp_k;

  assign ready       = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign RS_full_out = &busy_q;

  rs_priority_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_enc (
    .req   (~busy_q),
    .valid (free_valid),
    .idx   (free_idx)
  );

  rs_priority_enc #(.N(RS_SIZE), .W(IDX_W)) u_issue_enc (
    .req   (ready),
    .valid (issue_valid),
    .idx   (issue_idx)
  );

  // Per-entry tag compare against both broadcast buses
  for (genvar i = 0; i < RS_SIZE; i++) begin : g_snoop
    assign snp_j[i] = cdb_resolve(qj_busy_q[i], vj_q[i],
                                  ALU_CDB_flag_in && (qj_q[i] == ALU_CDB_idx_in), ALU_CDB_val_in,
                                  LSB_CDB_flag_in && (qj_q[i] == LSB_CDB_idx_in), LSB_CDB_val_in);
    assign snp_k[i] = cdb_resolve(qk_busy_q[i], vk_q[i],
                                  ALU_CDB_flag_in && (qk_q[i] == ALU_CDB_idx_in), ALU_CDB_val_in,
                                  LSB_CDB_flag_in && (qk_q[i] == LSB_CDB_idx_in), LSB_CDB_val_in);
  end

  // Dispatch bypass: operands produced on this cycle's CDBs are stored resolved
  assign disp_j = cdb_resolve(ID_Q1_busy_in, ID_val1_in,
                              ALU_CDB_flag_in && (ID_Q1_in == ALU_CDB_idx_in), ALU_CDB_val_in,
                              LSB_CDB_flag_in && (ID_Q1_in == LSB_CDB_idx_in), LSB_CDB_val_in);
  assign disp_k = cdb_resolve(ID_Q2_busy_in, ID_val2_in,
                              ALU_CDB_flag_in && (ID_Q2_in == ALU_CDB_idx_in), ALU_CDB_val_in,
                              LSB_CDB_flag_in && (ID_Q2_in == LSB_CDB_idx_in), LSB_CDB_val_in);

  // Next-state: stall > flush > snoop/issue/dispatch
  always_comb begin
    busy_d     = busy_q;
    qj_busy_d  = qj_busy_q;
    qk_busy_d  = qk_busy_q;
    op_d       = op_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    dest_d     = dest_q;
    alu_flag_d = 1'b0;
    alu_op_d   = alu_op_q;
    alu_val1_d = alu_val1_q;
    alu_val2_d = alu_val2_q;
    alu_idx_d  = alu_idx_q;

    if (!rdy) begin
      // Stall: entries and data outputs hold, issue valid drops
    end else if (ROB_clear_in) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          qj_busy_d[i] = snp_j[i].busy;
          vj_d[i]      = snp_j[i].val;
          qk_busy_d[i] = snp_k[i].busy;
          vk_d[i]      = snp_k[i].val;
        end
      end

      // A ready entry has no pending operand, so its registered fields are final
      if (issue_valid) begin
        alu_flag_d        = 1'b1;
        alu_op_d          = op_q[issue_idx];
        alu_val1_d        = vj_q[issue_idx];
        alu_val2_d        = vk_q[issue_idx];
        alu_idx_d         = dest_q[issue_idx];
        busy_d[issue_idx] = 1'b0;
      end

      // Free slot comes from pre-edge busy, so it never collides with the issuing entry
      if (ID_flag_in && free_valid) begin
        busy_d[free_idx]    = 1'b1;
        op_d[free_idx]      = ID_op_in;
        qj_busy_d[free_idx] = disp_j.busy;
        qj_d[free_idx]      = ID_Q1_in;
        vj_d[free_idx]      = disp_j.val;
        qk_busy_d[free_idx] = disp_k.busy;
        qk_d[free_idx]      = ID_Q2_in;
        vk_d[free_idx]      = disp_k.val;
        dest_d[free_idx]    = ID_idx_in_ROB_in;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      qj_busy_q  <= '0;
      qk_busy_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
      alu_flag_q <= 1'b0;
      alu_op_q   <= '0;
      alu_val1_q <= '0;
      alu_val2_q <= '0;
      alu_idx_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      qj_busy_q  <= qj_busy_d;
      qk_busy_q  <= qk_busy_d;
      op_q       <= op_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      dest_q     <= dest_d;
      alu_flag_q <= alu_flag_d;
      alu_op_q   <= alu_op_d;
      alu_val1_q <= alu_val1_d;
      alu_val2_q <= alu_val2_d;
      alu_idx_q  <= alu_idx_d;
    end
  end

  assign ALU_flag_out = alu_flag_q;
  assign ALU_op_out   = alu_op_q;
  assign ALU_val1_out = alu_val1_q;
  assign ALU_val2_out = alu_val2_q;
  assign ALU_idx_out  = alu_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// ============================================================================
// Module      : tb_reservation_station
// Description : Directed scenarios plus randomized traffic for the
//               reservation station, checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reservation_station;
  import reservation_station_pkg::*;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ID_flag_in;
  logic [5:0]  ID_op_in;
  logic        ID_Q1_busy_in;
  logic [3:0]  ID_Q1_in;
  logic [31:0] ID_val1_in;
  logic        ID_Q2_busy_in;
  logic [3:0]  ID_Q2_in;
  logic [31:0] ID_val2_in;
  logic [3:0]  ID_idx_in_ROB_in;
  logic        RS_full_out;
  logic        ALU_CDB_flag_in;
  logic [3:0]  ALU_CDB_idx_in;
  logic [31:0] ALU_CDB_val_in;
  logic        LSB_CDB_flag_in;
  logic [3:0]  LSB_CDB_idx_in;
  logic [31:0] LSB_CDB_val_in;
  logic        ROB_clear_in;
  logic        ALU_flag_out;
  logic [5:0]  ALU_op_out;
  logic [31:0] ALU_val1_out;
  logic [31:0] ALU_val2_out;
  logic [3:0]  ALU_idx_out;

  reservation_station #(.RS_SIZE(16), .ROB_IDX_W(4), .OP_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .ID_flag_in       (ID_flag_in),
    .ID_op_in         (ID_op_in),
    .ID_Q1_busy_in    (ID_Q1_busy_in),
    .ID_Q1_in         (ID_Q1_in),
    .ID_val1_in       (ID_val1_in),
    .ID_Q2_busy_in    (ID_Q2_busy_in),
    .ID_Q2_in         (ID_Q2_in),
    .ID_val2_in       (ID_val2_in),
    .ID_idx_in_ROB_in (ID_idx_in_ROB_in),
    .RS_full_out      (RS_full_out),
    .ALU_CDB_flag_in  (ALU_CDB_flag_in),
    .ALU_CDB_idx_in   (ALU_CDB_idx_in),
    .ALU_CDB_val_in   (ALU_CDB_val_in),
    .LSB_CDB_flag_in  (LSB_CDB_flag_in),
    .LSB_CDB_idx_in   (LSB_CDB_idx_in),
    .LSB_CDB_val_in   (LSB_CDB_val_in),
    .ROB_clear_in     (ROB_clear_in),
    .ALU_flag_out     (ALU_flag_out),
    .ALU_op_out       (ALU_op_out),
    .ALU_val1_out     (ALU_val1_out),
    .ALU_val2_out     (ALU_val2_out),
    .ALU_idx_out      (ALU_idx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        busy;
    bit [5:0]  op;
    bit        q1b;
    bit [3:0]  q1;
    bit [31:0] v1;
    bit        q2b;
    bit [3:0]  q2;
    bit [31:0] v2;
    bit [3:0]  dest;
  } ent_t;

  ent_t      m [16];
  bit        e_flag;
  bit [5:0]  e_op;
  bit [31:0] e_v1, e_v2;
  bit [3:0]  e_idx;

  function automatic bit [32:0] pick(input bit b, input bit [3:0] tag, input bit [31:0] v);
    if (!b) return {1'b0, v};
    if (ALU_CDB_flag_in && ALU_CDB_idx_in == tag) return {1'b0, ALU_CDB_val_in};
    if (LSB_CDB_flag_in && LSB_CDB_idx_in == tag) return {1'b0, LSB_CDB_val_in};
    return {1'b1, v};
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 16; i++) if (m[i].busy) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = '{default: 0};
    e_flag = 0; e_op = 0; e_v1 = 0; e_v2 = 0; e_idx = 0;
  endtask

  task automatic model_edge();
    int iss;
    int fre;
    bit [32:0] r;
    if (!rdy) begin
      e_flag = 0;
      return;
    end
    if (ROB_clear_in) begin
      for (int i = 0; i < 16; i++) m[i].busy = 0;
      e_flag = 0;
      return;
    end
    iss = -1;
    fre = -1;
    for (int i = 0; i < 16; i++) begin
      if (iss < 0 && m[i].busy && !m[i].q1b && !m[i].q2b) iss = i;
      if (fre < 0 && !m[i].busy) fre = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i].busy) begin
        r = pick(m[i].q1b, m[i].q1, m[i].v1); m[i].q1b = r[32]; m[i].v1 = r[31:0];
        r = pick(m[i].q2b, m[i].q2, m[i].v2); m[i].q2b = r[32]; m[i].v2 = r[31:0];
      end
    end
    e_flag = 0;
    if (iss >= 0) begin
      e_flag = 1;
      e_op = m[iss].op; e_v1 = m[iss].v1; e_v2 = m[iss].v2; e_idx = m[iss].dest;
      m[iss].busy = 0;
    end
    if (ID_flag_in && fre >= 0) begin
      m[fre].busy = 1;
      m[fre].op   = ID_op_in;
      r = pick(ID_Q1_busy_in, ID_Q1_in, ID_val1_in);
      m[fre].q1b = r[32]; m[fre].q1 = ID_Q1_in; m[fre].v1 = r[31:0];
      r = pick(ID_Q2_busy_in, ID_Q2_in, ID_val2_in);
      m[fre].q2b = r[32]; m[fre].q2 = ID_Q2_in; m[fre].v2 = r[31:0];
      m[fre].dest = ID_idx_in_ROB_in;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_flag"}, {31'd0, ALU_flag_out}, {31'd0, e_flag});
    chk({tag, "_op"},   {26'd0, ALU_op_out},   {26'd0, e_op});
    chk({tag, "_v1"},   ALU_val1_out,          e_v1);
    chk({tag, "_v2"},   ALU_val2_out,          e_v2);
    chk({tag, "_idx"},  {28'd0, ALU_idx_out},  {28'd0, e_idx});
    chk({tag, "_full"}, {31'd0, RS_full_out},  {31'd0, model_count() == 16});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rdy = 1; ROB_clear_in = 0;
    ID_flag_in = 0; ID_op_in = 0; ID_Q1_busy_in = 0; ID_Q1_in = 0; ID_val1_in = 0;
    ID_Q2_busy_in = 0; ID_Q2_in = 0; ID_val2_in = 0; ID_idx_in_ROB_in = 0;
    ALU_CDB_flag_in = 0; ALU_CDB_idx_in = 0; ALU_CDB_val_in = 0;
    LSB_CDB_flag_in = 0; LSB_CDB_idx_in = 0; LSB_CDB_val_in = 0;
  endtask

  task automatic disp(input bit [5:0] op, input bit q1b, input bit [3:0] q1, input bit [31:0] v1,
                      input bit q2b, input bit [3:0] q2, input bit [31:0] v2, input bit [3:0] dest);
    ID_flag_in = 1; ID_op_in = op;
    ID_Q1_busy_in = q1b; ID_Q1_in = q1; ID_val1_in = v1;
    ID_Q2_busy_in = q2b; ID_Q2_in = q2; ID_val2_in = v2;
    ID_idx_in_ROB_in = dest;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    compare_all("reset");

    // 1: async reset mid-run while an issue is on the output
    disp(OP_ADD, 1, 4'd9, 0, 0, 0, 32'd1, 4'd1); tick("t1_fill");
    tick("t1_fill");
    disp(OP_ADD, 0, 0, 32'd1, 0, 0, 32'd2, 4'd3); tick("t1_fill");
    idle(); tick("t1_iss");
    chk("t1_pre_flag", {31'd0, ALU_flag_out}, 32'd1);
    #2 rst = 0;
    #1;
    model_reset();
    chk("t1_rst_flag", {31'd0, ALU_flag_out}, 32'd0);
    chk("t1_rst_full", {31'd0, RS_full_out}, 32'd0);
    chk("t1_rst_v1", ALU_val1_out, 32'd0);
    #1 rst = 1;
    disp(OP_ADD, 0, 0, 32'd5, 0, 0, 32'd7, 4'd2); tick("t1_disp");
    idle(); tick("t1_out");
    chk("t1_flag", {31'd0, ALU_flag_out}, 32'd1);
    chk("t1_v1", ALU_val1_out, 32'd5);
    chk("t1_v2", ALU_val2_out, 32'd7);
    chk("t1_idx", {28'd0, ALU_idx_out}, 32'd2);

    // 2: operand resolved by ALU CDB
    disp(OP_SUB, 1, 4'd3, 0, 0, 0, 32'd1, 4'd6); tick("t2_disp");
    idle(); tick("t2_wait");
    ALU_CDB_flag_in = 1; ALU_CDB_idx_in = 4'd3; ALU_CDB_val_in = 32'd10; tick("t2_cdb");
    chk("t2_noissue", {31'd0, ALU_flag_out}, 32'd0);
    idle(); tick("t2_out");
    chk("t2_flag", {31'd0, ALU_flag_out}, 32'd1);
    chk("t2_op", {26'd0, ALU_op_out}, {26'd0, OP_SUB});
    chk("t2_v1", ALU_val1_out, 32'd10);
    chk("t2_v2", ALU_val2_out, 32'd1);
    chk("t2_idx", {28'd0, ALU_idx_out}, 32'd6);

    // 3: dispatch bypass from LSB CDB
    disp(OP_SLT, 0, 0, 32'd3, 1, 4'd5, 0, 4'd9);
    LSB_CDB_flag_in = 1; LSB_CDB_idx_in = 4'd5; LSB_CDB_val_in = 32'hDEADBEEF;
    tick("t3_disp");
    idle(); tick("t3_out");
    chk("t3_flag", {31'd0, ALU_flag_out}, 32'd1);
    chk("t3_v2", ALU_val2_out, 32'hDEADBEEF);
    chk("t3_idx", {28'd0, ALU_idx_out}, 32'd9);

    // 4: fill, drop the overflow dispatch, drain in index order
    for (int i = 0; i < 16; i++) begin
      disp(OP_ADD, 1, 4'd7, 0, 0, 0, 32'(i), 4'(i));
      tick("t4_fill");
    end
    chk("t4_full", {31'd0, RS_full_out}, 32'd1);
    disp(OP_OR, 0, 0, 32'd99, 0, 0, 32'h1234, 4'd0); tick("t4_drop");
    chk("t4_full2", {31'd0, RS_full_out}, 32'd1);
    idle();
    ALU_CDB_flag_in = 1; ALU_CDB_idx_in = 4'd7; ALU_CDB_val_in = 32'h70; tick("t4_cdb");
    idle();
    for (int i = 0; i < 16; i++) begin
      tick("t4_drain");
      chk("t4_flag", {31'd0, ALU_flag_out}, 32'd1);
      chk("t4_idx", {28'd0, ALU_idx_out}, 32'(i));
      chk("t4_v2", ALU_val2_out, 32'(i));
    end
    tick("t4_done");
    chk("t4_empty", {31'd0, ALU_flag_out}, 32'd0);

    // 5: flush with simultaneous dispatch and CDB
    disp(OP_AND, 1, 4'd8, 0, 0, 0, 32'd1, 4'd1); tick("t5_fill");
    disp(OP_AND, 0, 0, 32'd2, 1, 4'd8, 0, 4'd2); tick("t5_fill");
    disp(OP_XOR, 0, 0, 32'd4, 0, 0, 32'd5, 4'd3);
    ROB_clear_in = 1;
    ALU_CDB_flag_in = 1; ALU_CDB_idx_in = 4'd8; ALU_CDB_val_in = 32'd88;
    tick("t5_clr");
    chk("t5_flag", {31'd0, ALU_flag_out}, 32'd0);
    chk("t5_full", {31'd0, RS_full_out}, 32'd0);
    idle();
    ALU_CDB_flag_in = 1; ALU_CDB_idx_in = 4'd8; ALU_CDB_val_in = 32'd88; tick("t5_cdb");
    idle(); tick("t5_after");
    chk("t5_noissue", {31'd0, ALU_flag_out}, 32'd0);
    tick("t5_after2");
    chk("t5_noissue2", {31'd0, ALU_flag_out}, 32'd0);

    // 6: stall holds a ready entry
    disp(OP_ADD, 0, 0, 32'd11, 0, 0, 32'd22, 4'd4); tick("t6_disp");
    idle(); rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick("t6_stall");
      chk("t6_stall_flag", {31'd0, ALU_flag_out}, 32'd0);
    end
    rdy = 1; tick("t6_go");
    chk("t6_flag", {31'd0, ALU_flag_out}, 32'd1);
    chk("t6_v1", ALU_val1_out, 32'd11);
    chk("t6_v2", ALU_val2_out, 32'd22);
    chk("t6_idx", {28'd0, ALU_idx_out}, 32'd4);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy = ($urandom_range(0, 7) != 0);
      ROB_clear_in = ($urandom_range(0, 49) == 0);
      if (model_count() < 16 && $urandom_range(0, 2) != 0)
        disp(6'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) < 4) begin
        ALU_CDB_flag_in = 1; ALU_CDB_idx_in = 4'($urandom_range(0, 7)); ALU_CDB_val_in = $urandom;
      end
      if ($urandom_range(0, 9) < 4) begin
        LSB_CDB_flag_in = 1; LSB_CDB_idx_in = 4'($urandom_range(0, 7)); LSB_CDB_val_in = $urandom;
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
